// File: rtl/ula_exec.sv
// Multi-cycle 32-bit ALU: single-cycle add/sub/or/equal/less/and plus
// iterative signed multiply and divide with results held in HI/LO.
module ula_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_EQ   = 3'b011;
  localparam logic [2:0] OP_LT   = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Context latched at the start of a mult/div
  typedef struct packed {
    logic is_div;
    logic sign_a;
    logic sign_b;
    logic div_zero;
  } md_ctx_t;

  state_t           state, state_nxt;
  md_ctx_t          ctx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;     // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier->product lower half / dividend->quotient

  logic             md_op;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign md_op = (opCode == OP_MULT) || (opCode == OP_DIV);
  assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    simple_res = '0;
    case (opCode)
      OP_ADD: simple_res = a + b;
      OP_SUB: simple_res = a - b;
      OP_OR:  simple_res = a | b;
      OP_EQ:  simple_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_AND: simple_res = a & b;
      default: simple_res = '0;
    endcase
  end

  // One shift-add multiply step on the {acc_hi, acc_lo} pair
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

  // One restoring divide step; the shifted partial remainder needs WIDTH+1 bits
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next, div_q_next;
  assign div_shift    = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, opnd};
  assign div_diff     = div_shift - {1'b0, opnd};
  assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_q_next   = {acc_lo[WIDTH-2:0], div_ge};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (ctx.sign_a ^ ctx.sign_b) ? (~prod + 1'b1) : prod;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (ctx.is_div) begin
      if (ctx.div_zero) begin
        // Dividend magnitude is still untouched in acc_lo; rebuild a
        fix_lo = '1;
        fix_hi = ctx.sign_a ? (~acc_lo + 1'b1) : acc_lo;
      end else begin
        fix_lo = (ctx.sign_a ^ ctx.sign_b) ? (~acc_lo + 1'b1) : acc_lo;
        fix_hi = ctx.sign_a ? (~acc_hi + 1'b1) : acc_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && md_op) state_nxt = CALC;
      CALC: if (ctx.div_zero || cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx    <= '0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (md_op) begin
              ctx.is_div   <= (opCode == OP_DIV);
              ctx.sign_a   <= a[WIDTH-1];
              ctx.sign_b   <= b[WIDTH-1];
              ctx.div_zero <= (opCode == OP_DIV) && (b == '0);
              cnt          <= '0;
              acc_hi       <= '0;
              if (opCode == OP_DIV) begin
                opnd   <= mag_b;
                acc_lo <= mag_a;
              end else begin
                opnd   <= mag_a;
                acc_lo <= mag_b;
              end
            end else begin
              result <= simple_res;
              zero   <= (simple_res == '0);
              done   <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!ctx.div_zero) begin
            if (ctx.is_div) begin
              acc_hi <= div_rem_next;
              acc_lo <= div_q_next;
            end else begin
              acc_hi <= mul_next[2*WIDTH-1:WIDTH];
              acc_lo <= mul_next[WIDTH-1:0];
            end
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi     <= fix_hi;
          lo     <= fix_lo;
          result <= fix_lo;
          zero   <= (fix_lo == '0);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_exec.sv
// Directed bench for ula_exec: table of single-cycle vectors plus
// hand-written mult/div, restart-while-busy and reset-abort sequences.
module tb_ula_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opCode = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  ula_exec #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opCode(opCode), .a(a), .b(b),
    .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Start pulse sampled by the next rising edge; checks land in cycle 1
  task automatic run_simple(input vec_t v);
    @(negedge clk);
    start = 1'b1; opCode = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    chk({v.name, ".result"}, result, v.res);
    chk({v.name, ".zero"}, {31'b0, zero}, {31'b0, v.zero});
    chk({v.name, ".done"}, {31'b0, done}, 32'd1);
    chk({v.name, ".hi_kept"}, hi, mdl_hi);
    chk({v.name, ".lo_kept"}, lo, mdl_lo);
    @(negedge clk);
    chk({v.name, ".done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic run_md(input string name, input logic [2:0] op,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int exp_cyc, input int restart_at);
    int done_cyc, n_done, n_busy;
    logic [31:0] got_lo, got_hi, got_res;
    logic got_zero;
    done_cyc = -1; n_done = 0; n_busy = 0;
    got_lo = 'x; got_hi = 'x; got_res = 'x; got_zero = 1'bx;
    @(negedge clk);
    start = 1'b1; opCode = op; a = va; b = vb;
    for (int cyc = 1; cyc <= exp_cyc + 3; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      opCode = 3'b000; a = $urandom; b = $urandom;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; got_lo = lo; got_hi = hi; got_res = result; got_zero = zero;
        end
      end
    end
    start = 1'b0;
    chk({name, ".done_cycle"}, done_cyc, exp_cyc);
    chk({name, ".done_count"}, n_done, 1);
    chk({name, ".busy_cycles"}, n_busy, exp_cyc - 1);
    chk({name, ".lo"}, got_lo, exp_lo);
    chk({name, ".hi"}, got_hi, exp_hi);
    chk({name, ".result"}, got_res, exp_lo);
    chk({name, ".zero"}, {31'b0, got_zero}, {31'b0, exp_lo == 32'd0});
    mdl_hi = exp_hi; mdl_lo = exp_lo;
  endtask

  initial begin
    vecs.push_back('{"add",     3'b000, 32'd5,        32'd7,        32'd12,       1'b0});
    vecs.push_back('{"sub_neg", 3'b001, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"or",      3'b010, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0});
    vecs.push_back('{"eq_t",    3'b011, 32'd9,        32'd9,        32'd1,        1'b0});
    vecs.push_back('{"eq_f",    3'b011, 32'd9,        32'd8,        32'd0,        1'b1});
    vecs.push_back('{"lt_neg",  3'b100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0});
    vecs.push_back('{"lt_pos",  3'b100, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1});
    vecs.push_back('{"lt_min",  3'b100, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0});
    vecs.push_back('{"and",     3'b111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0});
    vecs.push_back('{"sub_eq",  3'b001, 32'h12345678, 32'h12345678, 32'd0,        1'b1});
    vecs.push_back('{"add_wr",  3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1});

    #12;
    chk("rst.result", result, 32'd0);
    chk("rst.zero", {31'b0, zero}, 32'd1);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_simple(vecs[i]);

    run_md("mult_m3x7",  3'b101, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 34, 0);
    run_md("mult_restart", 3'b101, 32'd100, 32'hFFFFFFFB, 32'hFFFFFE0C, 32'hFFFFFFFF, 34, 10);
    run_md("div_m7d2",   3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 0);
    run_md("div_by0",    3'b110, 32'd10, 32'd0, 32'hFFFFFFFF, 32'd10, 3, 0);
    run_md("div_7dm2",   3'b110, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 34, 0);
    run_md("div_min",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 34, 0);
    run_md("mult_min",   3'b101, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 34, 0);

    // Single-cycle op after mult/div must leave hi/lo alone
    run_simple(vecs[0]);

    // Abort a divide at cycle 15
    @(negedge clk);
    start = 1'b1; opCode = 3'b110; a = 32'd1000; b = 32'd3;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort.busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.result", result, 32'd0);
    chk("abort.zero", {31'b0, zero}, 32'd1);
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    chk("abort.hi", hi, 32'd0);
    chk("abort.lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_hi = '0; mdl_lo = '0;
    run_simple(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
